// File: rtl/adder_share_sched_if.sv
// Request/result bundle for adder_share_sched: two add requesters, one result
// consumer and the busy flag.
interface adder_share_sched_if #(
  parameter int unsigned NIB = 4
);
  localparam int unsigned W = 4 * NIB;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id, busy
  );
endinterface

// File: rtl/adder_share_sched.sv
// Two-requester W-bit adder built from a single 4-bit slice, processed one
// nibble per cycle LSB first, with round-robin arbitration between requests.
module adder_share_sched #(
  parameter int unsigned NIB = 4
) (
  input logic                clk,
  input logic                rst,
  adder_share_sched_if.slave bus
);
  localparam int unsigned W    = 4 * NIB;
  localparam int unsigned IW   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          id_q, id_d;
  logic          prio_q, prio_d;

  logic          grant0, grant1;
  logic [3:0]    slice_a, slice_b, slice_s;
  logic          slice_c;

  // Priority only matters when both requesters are valid at once.
  always_comb begin
    grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio_q);
    grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid ||  prio_q);
  end

  // The one shared 4-bit full-adder slice, fed from the nibble selected by idx_q.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        slice_a = a_q[4*i +: 4];
        slice_b = b_q[4*i +: 4];
      end
    end
    {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    id_d    = id_q;
    prio_d  = prio_q;

    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          carry_d = bus.req0_cin;
          id_d    = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end else if (grant1) begin
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          carry_d = bus.req1_cin;
          id_d    = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) sum_d[4*i +: 4] = slice_s;
        end
        carry_d = slice_c;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  // After the last slice the carry register holds the final carry-out.
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.res_valid  = (state_q == DONE);
  assign bus.res_sum    = sum_q;
  assign bus.res_cout   = carry_q;
  assign bus.res_id     = id_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched: directed cases plus randomized
// jobs checked against an arithmetic/round-robin reference model.
module tb_adder_share_sched;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_sched_if #(.NIB(NIB)) bus ();
  adder_share_sched #(.NIB(NIB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int  tests = 0;
  int  fails = 0;
  bit  exp_prio;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic int ref_grant(input logic v0, input logic v1);
    if (v0 && v1) return exp_prio ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus.res_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_prio = 1'b0;
  endtask

  // Drives one job to completion; reports grant, latency and the captured result.
  task automatic run_job(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                         input bit keep, input int ready_delay,
                         output int gid, output int lat,
                         output logic [W-1:0] sum, output logic cout, output logic id);
    int n;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_cin = c0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_cin = c1;
    bus.res_ready  = 1'b0;
    #1;
    n = 0;
    while (!(bus.req0_ready || bus.req1_ready) && n < 10) begin
      tick();
      n++;
    end
    gid = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
    sum = '0; cout = 1'b0; id = 1'b0; lat = -1;
    if (gid < 0) return;
    tick();
    if (!keep) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_cin = 1'($urandom);
      bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_cin = 1'($urandom);
    end
    lat = 0;
    while (!bus.res_valid && lat < 3*NIB + 4) begin
      tick();
      lat++;
    end
    for (int d = 0; d < ready_delay; d++) tick();
    sum  = bus.res_sum;
    cout = bus.res_cout;
    id   = bus.res_id;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req0_valid = 1'b1;
    bus.res_ready  = 1'b1;
    do_reset();
    bus.req0_valid = 1'b0;
    bus.res_ready  = 1'b0;
    #1;
    tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.res_sum !== '0) begin fails++; $display("FAIL reset_res_sum got=%h exp=0", bus.res_sum); end
    tests++; if (bus.res_cout !== 1'b0 || bus.res_id !== 1'b0) begin fails++; $display("FAIL reset_cout_id got=%b%b exp=00", bus.res_cout, bus.res_id); end
    tests++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
  endtask

  task automatic test_directed();
    int gid, lat; logic [W-1:0] sum; logic cout, id;
    run_job(1'b1, 16'h1234, 16'h0FCD, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 0, gid, lat, sum, cout, id);
    exp_prio = 1'b1;
    tests++; if (gid !== 0) begin fails++; $display("FAIL dir0_grant got=%0d exp=0", gid); end
    tests++; if (lat !== NIB) begin fails++; $display("FAIL dir0_latency got=%0d exp=%0d", lat, NIB); end
    tests++; if (sum !== 16'h2201 || cout !== 1'b0 || id !== 1'b0) begin fails++; $display("FAIL dir0_result got=%h/%b/%b exp=2201/0/0", sum, cout, id); end
    run_job(1'b0, '0, '0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, gid, lat, sum, cout, id);
    exp_prio = 1'b0;
    tests++; if (gid !== 1) begin fails++; $display("FAIL dir1_grant got=%0d exp=1", gid); end
    tests++; if (lat !== NIB) begin fails++; $display("FAIL dir1_latency got=%0d exp=%0d", lat, NIB); end
    tests++; if (sum !== 16'h0000 || cout !== 1'b1 || id !== 1'b1) begin fails++; $display("FAIL dir1_result got=%h/%b/%b exp=0000/1/1", sum, cout, id); end
  endtask

  task automatic test_priority();
    int gid, lat; logic [W-1:0] sum; logic cout, id;
    int order [4] = '{0, 1, 0, 1};
    clear_inputs();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_job(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 0, gid, lat, sum, cout, id);
      tests++; if (gid !== order[k] || gid !== ref_grant(1'b1, 1'b1)) begin fails++; $display("FAIL prio_order[%0d] got=%0d exp=%0d", k, gid, order[k]); end
      tests++; if (sum !== 16'h0000 || cout !== 1'b1 || id !== 1'(order[k])) begin fails++; $display("FAIL prio_result[%0d] got=%h/%b/%b exp=0000/1/%0d", k, sum, cout, id, order[k]); end
      tests++; if (lat !== NIB) begin fails++; $display("FAIL prio_latency[%0d] got=%0d exp=%0d", k, lat, NIB); end
      exp_prio = (gid == 0);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [W:0] r;
    int g;
    g = ref_grant(1'b1, 1'b0);
    r = ref_add(16'hA5A5, 16'h5A5B, 1'b1);
    bus.req0_valid = 1'b1; bus.req0_a = 16'hA5A5; bus.req0_b = 16'h5A5B; bus.req0_cin = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    for (int k = 0; k < NIB; k++) tick();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (bus.res_valid !== 1'b1 || bus.res_sum !== r[W-1:0] || bus.res_cout !== r[W] || bus.res_id !== 1'(g)
          || bus.busy !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d] got v=%b s=%h c=%b id=%b busy=%b rdy=%b%b exp v=1 s=%h c=%b id=%0d busy=1 rdy=00",
                 k, bus.res_valid, bus.res_sum, bus.res_cout, bus.res_id, bus.busy, bus.req0_ready, bus.req1_ready, r[W-1:0], r[W], g);
      end
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    tests++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin fails++; $display("FAIL handshake_ready got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
    tick();
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    exp_prio = (g == 0);
    #1;
    tests++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL after_handshake got v=%b busy=%b exp=0/0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_reset_midrun();
    int gid, lat; logic [W-1:0] sum; logic cout, id;
    bit seen;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h7777; bus.req1_b = 16'h1111; bus.req1_cin = 1'b0;
    #1;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b0;
    exp_prio = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_sum !== '0) begin fails++; $display("FAIL midrun_reset got busy=%b v=%b s=%h exp=0/0/0000", bus.busy, bus.res_valid, bus.res_sum); end
    seen = 1'b0;
    for (int k = 0; k < 2*NIB; k++) begin
      if (bus.res_valid) seen = 1'b1;
      tick();
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrun_no_result got=%b exp=0", seen); end
    run_job(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 0, gid, lat, sum, cout, id);
    exp_prio = 1'b1;
    tests++; if (gid !== 0 || lat !== NIB || sum !== 16'h0002 || cout !== 1'b0 || id !== 1'b0) begin fails++; $display("FAIL post_reset_job got g=%0d lat=%0d s=%h c=%b id=%b exp g=0 lat=%0d s=0002 c=0 id=0", gid, lat, sum, cout, id, NIB); end
  endtask

  task automatic test_random();
    int gid, lat, eg, r3; logic [W-1:0] sum; logic cout, id;
    logic v0, v1, c0, c1; logic [W-1:0] a0, b0, a1, b1; logic [W:0] r;
    for (int k = 0; k < 24; k++) begin
      r3 = int'($urandom_range(1, 3));
      v0 = r3[0]; v1 = r3[1];
      a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
      if (k == 0) begin a0 = '1; b0 = '1; c0 = 1'b1; end
      eg = ref_grant(v0, v1);
      r  = (eg == 0) ? ref_add(a0, b0, c0) : ref_add(a1, b1, c1);
      run_job(v0, a0, b0, c0, v1, a1, b1, c1, 1'b0, int'($urandom_range(0, 3)), gid, lat, sum, cout, id);
      tests++;
      if (gid !== eg || lat !== NIB || sum !== r[W-1:0] || cout !== r[W] || id !== 1'(eg)) begin
        fails++;
        $display("FAIL random[%0d] got g=%0d lat=%0d s=%h c=%b id=%b exp g=%0d lat=%0d s=%h c=%b",
                 k, gid, lat, sum, cout, id, eg, NIB, r[W-1:0], r[W]);
      end
      exp_prio = (eg == 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_directed();
    test_priority();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_share_sched.md
ADDER_SHARE_SCHED -- requirements
Module: adder_share_sched

Interface
REQ-001 SHALL have parameter NIB, default 4, number of 4-bit slices; operand width W = 4*NIB.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester N has an add pending.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester N accepted on the edge where valid&ready.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W  operands.
REQ-007 SHALL have ports req0_cin/req1_cin  input  1  carry-in.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_sum  output  W  sum.
REQ-011 SHALL have port res_cout  output  1  carry-out.
REQ-012 SHALL have port res_id  output  1  requester served (0/1).
REQ-013 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-014 SHALL contain exactly one 4-bit full-adder slice (4b+4b+cin -> 4b sum, cout), time-shared across slices and requesters.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE, drive ready high for exactly one requester: the only valid one, or, if both valid, the one holding priority; both ready low if neither valid.
REQ-017 SHALL, on accept edge, latch a, b, cin, id; clear slice index to 0; load carry register with cin; move to RUN.
REQ-018 SHALL, in RUN, each cycle add slice [4i+3:4i] of a and b with the carry register, write the 4-bit sum into result bits [4i+3:4i], update carry register with slice cout, increment i.
REQ-019 SHALL move RUN -> DONE on the edge processing slice NIB-1; res_valid rises exactly NIB cycles after the accept edge.
REQ-020 SHALL produce res_sum = (a+b+cin) mod 2^W and res_cout = bit W of a+b+cin.
REQ-021 SHALL, in DONE, hold res_valid, res_sum, res_cout, res_id stable until res_valid&res_ready.
REQ-022 SHALL, on result handshake, go to IDLE and give priority to the requester not just served.
REQ-023 SHALL keep both ready outputs low in RUN and DONE; no new accept in the DONE handshake cycle (one IDLE cycle minimum between jobs).
REQ-024 SHALL ignore requester inputs changing after accept; latched copies are used.
REQ-025 SHALL keep res_valid low in IDLE and RUN.

Reset
REQ-026 SHALL, when rst high at an edge, enter IDLE, set res_valid, res_sum, res_cout, res_id, busy, slice index, carry register to 0, priority to requester 0.
REQ-027 SHALL, on rst during RUN or DONE, discard the in-flight job; no result emitted for it.
REQ-028 SHALL give rst precedence over any handshake in the same cycle.

Verification (NIB=4)
REQ-029 SHALL pass: req0 a=0x1234 b=0x0FCD cin=0 -> res_sum=0x2201 cout=0 id=0, res_valid 4 cycles after accept.
REQ-030 SHALL pass: req1 a=0xFFFF b=0x0000 cin=1 -> res_sum=0x0000 cout=1 id=1 (carry ripples all slices).
REQ-031 SHALL pass: both valid continuously after reset, res_ready=1 -> grant order 0,1,0,1; a=0x8000 b=0x8000 -> sum=0x0000 cout=1.
REQ-032 SHALL pass: res_ready low 5 cycles in DONE -> res_valid and outputs held, busy=1, both ready=0; completes on res_ready=1.
REQ-033 SHALL pass: rst pulsed at slice 2 of RUN -> next cycle IDLE, busy=0, res_valid never rises for that job; following request a=0x0001 b=0x0001 -> sum=0x0002.
